// File: rtl/phase_pkg.sv
// phase_pkg: shared encodings and helpers
// for the N-phase supply monitor.
package phase_pkg;

   typedef enum logic {
      DIR_FWD = 1'b0,
      DIR_REV = 1'b1
   } dir_e;

   localparam int PH_W = 3;

   typedef logic [PH_W-1:0] ph_idx_t;

   // Expected successor of idx when rotating in dir, wrapping mod nph.
   function automatic ph_idx_t next_ph(
      input ph_idx_t idx,
      input logic    dir,
      input int      nph
   );
      ph_idx_t w_top;
      w_top = ph_idx_t'(nph - 1);
      if (dir == DIR_FWD)
         return (idx == w_top) ? '0 : idx + ph_idx_t'(1);
      else
         return (idx == '0) ? w_top : idx - ph_idx_t'(1);
   endfunction

endpackage

// File: rtl/phase_monitor_if.sv
// phase_monitor_if: sample strobe, direction,
// raw phases in; debounced status out.
interface phase_monitor_if #(
   parameter int NPH = 3
);
   logic           enable;
   logic           dir;
   logic [NPH-1:0] phase_in;
   logic [NPH-1:0] phase_db;
   logic [NPH-1:0] phase_rise;
   logic [NPH-1:0] missing;
   logic           any_missing;
   logic           rot_ok;
   logic           rot_rev;
   logic           ref_gate;

   modport master (
      output enable, dir, phase_in,
      input  phase_db, phase_rise, missing,
      input  any_missing, rot_ok, rot_rev, ref_gate
   );

   modport slave (
      input  enable, dir, phase_in,
      output phase_db, phase_rise, missing,
      output any_missing, rot_ok, rot_rev, ref_gate
   );
endinterface

// File: rtl/phase_chan.sv
// phase_chan: one phase lane -- synchroniser,
// debounce, rise pulse and missing timer.
module phase_chan #(
   parameter int DEB_W      = 4,
   parameter int DEB_COUNT  = 12,
   parameter int MISS_W     = 8,
   parameter int MISS_TICKS = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_ph,
   output logic o_db,
   output logic o_rise,
   output logic o_missing
);
   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_COUNT - 1);
   localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_TICKS);

   logic [1:0]        r_sync;
   logic [DEB_W-1:0]  r_cnt;
   logic              r_db;
   logic              r_db_q;
   logic              r_rise;
   logic [MISS_W-1:0] r_tmr;
   logic              w_s;

   assign w_s = r_sync[1];

   // Two-flop synchroniser for the asynchronous raw input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[0], i_ph};
   end

   // Debounce: toggle after DEB_COUNT consecutive differing ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_db  <= 1'b0;
      end else if (w_s == r_db) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (r_cnt == DEB_LAST) begin
            r_db  <= ~r_db;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + DEB_W'(1);
         end
      end
   end

   // Registered one-cycle pulse on a debounced rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_db_q <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_db_q <= r_db;
         r_rise <= r_db & ~r_db_q;
      end
   end

   // Missing timer: ticks since last rise, saturating at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        r_tmr <= '0;
      else if (r_rise)                   r_tmr <= '0;
      else if (i_en && r_tmr != MISS_MAX) r_tmr <= r_tmr + MISS_W'(1);
   end

   assign o_db      = r_db;
   assign o_rise    = r_rise;
   assign o_missing = (r_tmr == MISS_MAX);

endmodule

// File: rtl/phase_monitor.sv
// phase_monitor: N-phase mains monitor -- per-phase
// lanes plus rotation sequence qualification.
module phase_monitor
   import phase_pkg::*;
#(
   parameter int NPH        = 3,
   parameter int DEB_W      = 4,
   parameter int DEB_COUNT  = 12,
   parameter int MISS_W     = 8,
   parameter int MISS_TICKS = 200,
   parameter int ROT_W      = 4,
   parameter int ROT_MAX    = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   phase_monitor_if.slave  bus
);
   localparam logic [ROT_W-1:0] RMAX = ROT_W'(ROT_MAX);

   logic [NPH-1:0]   w_db;
   logic [NPH-1:0]   w_rise;
   logic [NPH-1:0]   w_miss;
   logic             w_any;
   logic             w_single;
   logic             w_multi;
   logic             w_step_dir;
   logic             w_step_opp;
   ph_idx_t          w_k;
   ph_idx_t          w_last_n;
   logic             w_valid_n;
   logic [ROT_W-1:0] w_fwd_n;
   logic [ROT_W-1:0] w_rev_n;

   ph_idx_t          r_last;
   logic             r_valid;
   logic             r_dir_q;
   logic [ROT_W-1:0] r_fwd;
   logic [ROT_W-1:0] r_rev;
   logic             r_ok;
   logic             r_rv;

   for (genvar gi = 0; gi < NPH; gi++) begin : g_ch
      phase_chan #(
         .DEB_W      (DEB_W),
         .DEB_COUNT  (DEB_COUNT),
         .MISS_W     (MISS_W),
         .MISS_TICKS (MISS_TICKS)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_en      (bus.enable),
         .i_ph      (bus.phase_in[gi]),
         .o_db      (w_db[gi]),
         .o_rise    (w_rise[gi]),
         .o_missing (w_miss[gi])
      );
   end

   assign w_any    = |w_miss;
   assign w_single = ($countones(w_rise) == 1);
   assign w_multi  = ($countones(w_rise) > 1);

   // Index of the rising phase when exactly one rises.
   always_comb begin
      w_k = '0;
      for (int i = 0; i < NPH; i++)
         if (w_rise[i]) w_k = ph_idx_t'(i);
   end

   assign w_step_dir = r_valid &&
                       (w_k == next_ph(r_last, bus.dir, NPH));
   assign w_step_opp = r_valid &&
                       (w_k == next_ph(r_last, ~bus.dir, NPH));

   // Next tracker state; missing phases outrank any edge.
   always_comb begin
      w_fwd_n   = r_fwd;
      w_rev_n   = r_rev;
      w_last_n  = r_last;
      w_valid_n = r_valid;
      if (w_any || w_multi) begin
         w_fwd_n   = '0;
         w_rev_n   = '0;
         w_valid_n = 1'b0;
      end else if (w_single) begin
         w_fwd_n = '0;
         w_rev_n = '0;
         if (w_step_dir)
            w_fwd_n = (r_fwd == RMAX) ? RMAX : r_fwd + ROT_W'(1);
         else if (w_step_opp)
            w_rev_n = (r_rev == RMAX) ? RMAX : r_rev + ROT_W'(1);
         w_last_n  = w_k;
         w_valid_n = 1'b1;
      end
      if (bus.dir != r_dir_q) begin
         w_fwd_n = '0;
         w_rev_n = '0;
      end
   end

   // Tracker and registered rotation flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last  <= '0;
         r_valid <= 1'b0;
         r_dir_q <= 1'b0;
         r_fwd   <= '0;
         r_rev   <= '0;
         r_ok    <= 1'b0;
         r_rv    <= 1'b0;
      end else begin
         r_last  <= w_last_n;
         r_valid <= w_valid_n;
         r_dir_q <= bus.dir;
         r_fwd   <= w_fwd_n;
         r_rev   <= w_rev_n;
         r_ok    <= (w_fwd_n == RMAX);
         r_rv    <= (w_rev_n == RMAX);
      end
   end

   assign bus.phase_db    = w_db;
   assign bus.phase_rise  = w_rise;
   assign bus.missing     = w_miss;
   assign bus.any_missing = w_any;
   assign bus.rot_ok      = r_ok;
   assign bus.rot_rev     = r_rv;
   assign bus.ref_gate    = w_db[0] & r_ok & ~w_any;

endmodule

// File: tb/tb_phase_monitor.sv
// tb_phase_monitor: scenario tasks checked against
// a behavioural model of the monitor rules.
`timescale 1ns/1ps
module tb_phase_monitor;
   localparam int NPH  = 3;
   localparam int DEB  = 4;
   localparam int MISS = 64;
   localparam int ROT  = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   t_w   = 0;

   always #5 clk = ~clk;

   phase_monitor_if #(.NPH(NPH)) bus ();

   phase_monitor #(
      .NPH(NPH), .DEB_W(4), .DEB_COUNT(DEB),
      .MISS_W(8), .MISS_TICKS(MISS),
      .ROT_W(4), .ROT_MAX(ROT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- reference model ----------------
   int m_s1[3], m_s2[3], m_cnt[3], m_tmr[3];
   bit m_db[3], m_pend[3], m_rise[3];
   int m_last = 0, m_fwd = 0, m_rev = 0;
   bit m_valid = 0, m_pdir = 0, m_ok = 0, m_rv = 0;

   initial begin : model
      int nr, k, want, opp;
      bit anym;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
               m_s1[i] = 0; m_s2[i] = 0; m_cnt[i] = 0; m_tmr[i] = 0;
               m_db[i] = 0; m_pend[i] = 0; m_rise[i] = 0;
            end
            m_last = 0; m_fwd = 0; m_rev = 0;
            m_valid = 0; m_pdir = 0; m_ok = 0; m_rv = 0;
         end else begin
            anym = 0; nr = 0; k = 0;
            for (int i = 0; i < 3; i++) begin
               if (m_tmr[i] == MISS) anym = 1;
               if (m_rise[i]) begin nr++; k = i; end
            end
            if (anym || nr > 1) begin
               m_fwd = 0; m_rev = 0; m_valid = 0;
            end else if (nr == 1) begin
               want = bus.dir ? (m_last + 2) % 3 : (m_last + 1) % 3;
               opp  = bus.dir ? (m_last + 1) % 3 : (m_last + 2) % 3;
               if (m_valid && k == want) begin
                  m_fwd = (m_fwd + 1 > ROT) ? ROT : m_fwd + 1;
                  m_rev = 0;
               end else if (m_valid && k == opp) begin
                  m_rev = (m_rev + 1 > ROT) ? ROT : m_rev + 1;
                  m_fwd = 0;
               end else begin
                  m_fwd = 0; m_rev = 0;
               end
               m_last = k; m_valid = 1;
            end
            if (bus.dir != m_pdir) begin m_fwd = 0; m_rev = 0; end
            m_pdir = bus.dir;
            m_ok = (m_fwd == ROT);
            m_rv = (m_rev == ROT);
            for (int i = 0; i < 3; i++) begin
               if (m_rise[i]) m_tmr[i] = 0;
               else if (bus.enable && m_tmr[i] < MISS) m_tmr[i]++;
               m_rise[i] = m_pend[i];
               m_pend[i] = 0;
               if (m_s2[i] == int'(m_db[i])) m_cnt[i] = 0;
               else if (bus.enable) begin
                  if (m_cnt[i] == DEB - 1) begin
                     m_db[i] = !m_db[i];
                     m_cnt[i] = 0;
                     if (m_db[i]) m_pend[i] = 1;
                  end else m_cnt[i]++;
               end
               m_s2[i] = m_s1[i];
               m_s1[i] = int'(bus.phase_in[i]);
            end
         end
      end
   end

   function automatic logic [12:0] exp_vec();
      logic [2:0] db, rs, ms;
      logic any;
      for (int i = 0; i < 3; i++) begin
         db[i] = m_db[i];
         rs[i] = m_rise[i];
         ms[i] = (m_tmr[i] == MISS);
      end
      any = |ms;
      return {db, rs, ms, any, m_ok, m_rv, db[0] & m_ok & ~any};
   endfunction

   function automatic logic [12:0] obs_vec();
      return {bus.phase_db, bus.phase_rise, bus.missing,
              bus.any_missing, bus.rot_ok, bus.rot_rev, bus.ref_gate};
   endfunction

   // Balanced 3-phase square wave, period 120, 40 clk phase spacing.
   function automatic logic [2:0] wave(int t, bit rev);
      logic [2:0] w;
      int r;
      for (int i = 0; i < 3; i++) begin
         r = rev ? ((3 - i) % 3) * 40 : i * 40;
         w[i] = (((t + 120 - r) % 120) < 60);
      end
      return w;
   endfunction

   function automatic logic par();
      return (cyc % 2) == 0;
   endfunction

   task automatic tick(input logic [2:0] pin, input logic en);
      @(posedge clk);
      #1;
      bus.phase_in = pin;
      bus.enable   = en;
      cyc++;
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      bus.enable = 1'b0; bus.dir = 1'b0; bus.phase_in = '0;
      repeat (3) @(negedge clk);
      total++;
      if (obs_vec() !== 13'd0) begin
         bad++;
         $display("FAIL reset_hold got=%b want=0", obs_vec());
      end
      @(posedge clk); #1 rst_n = 1'b1;
      tick(3'b000, 1'b0);
      tick(3'b000, 1'b0);
      total++;
      if (obs_vec() !== 13'd0 || exp_vec() !== 13'd0) begin
         bad++;
         $display("FAIL reset_after got=%b want=0", obs_vec());
      end
   endtask

   task automatic test_debounce();
      tick(3'b001, 1'b1);
      for (int c = 1; c <= 8; c++) begin
         tick(3'b001, 1'b1);
         total++;
         if ({bus.phase_db[0], bus.phase_rise[0]} !==
             {1'(c >= 6), 1'(c == 7)}) begin
            bad++;
            $display("FAIL deb_latency c=%0d got=%b%b want=%b%b", c,
                     bus.phase_db[0], bus.phase_rise[0], c >= 6, c == 7);
         end
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL deb_model got=%b want=%b", obs_vec(), exp_vec());
         end
      end
      repeat (3) tick(3'b000, 1'b1);
      for (int c = 0; c < 12; c++) begin
         tick(3'b001, 1'b1);
         total++;
         if (bus.phase_db[0] !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL glitch c=%0d got=%b want=%b", c,
                     obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      logic [2:0] pin;
      pin = 3'b001;
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 7) == 0) pin[i] = ~pin[i];
         if ($urandom_range(0, 99) == 0) bus.dir = ~bus.dir;
         tick(pin, 1'($urandom_range(0, 3) != 0));
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL rand n=%0d got=%b want=%b", n,
                     obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_forward();
      bus.dir = 1'b0;
      for (int n = 0; n < 2400; n++) begin
         tick(wave(t_w, 1'b0), par()); t_w++;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL fwd n=%0d got=%b want=%b", n,
                     obs_vec(), exp_vec());
         end
      end
      total++;
      if ({bus.rot_ok, bus.rot_rev, bus.any_missing} !== 3'b100) begin
         bad++;
         $display("FAIL fwd_qual got=%b%b%b want=100",
                  bus.rot_ok, bus.rot_rev, bus.any_missing);
      end
   endtask

   task automatic test_reverse();
      bus.dir = 1'b0;
      for (int n = 0; n < 2400; n++) begin
         tick(wave(t_w, 1'b1), par()); t_w++;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL rev n=%0d got=%b want=%b", n,
                     obs_vec(), exp_vec());
         end
      end
      total++;
      if ({bus.rot_ok, bus.rot_rev, bus.ref_gate} !== 3'b010) begin
         bad++;
         $display("FAIL rev_qual got=%b%b%b want=010",
                  bus.rot_ok, bus.rot_rev, bus.ref_gate);
      end
      bus.dir = 1'b1;
      tick(wave(t_w, 1'b1), par()); t_w++;
      total++;
      if ({bus.rot_ok, bus.rot_rev} !== 2'b00) begin
         bad++;
         $display("FAIL dir_flip got=%b%b want=00", bus.rot_ok, bus.rot_rev);
      end
      for (int n = 0; n < 2400; n++) begin
         tick(wave(t_w, 1'b1), par()); t_w++;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL rev_dir1 n=%0d got=%b want=%b", n,
                     obs_vec(), exp_vec());
         end
      end
      total++;
      if ({bus.rot_ok, bus.rot_rev} !== 2'b10) begin
         bad++;
         $display("FAIL requal got=%b%b want=10", bus.rot_ok, bus.rot_rev);
      end
   endtask

   task automatic test_missing();
      bit seen;
      seen = 0;
      for (int n = 0; n < 400 && !seen; n++) begin
         tick(wave(t_w, 1'b1) & 3'b101, par()); t_w++;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL miss n=%0d got=%b want=%b", n,
                     obs_vec(), exp_vec());
         end
         if (bus.missing[1] === 1'b1) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL miss_timeout got=%b want=010", bus.missing);
      end else if ({bus.missing, bus.any_missing} !== 4'b0101) begin
         bad++;
         $display("FAIL miss_flags got=%b%b want=0101",
                  bus.missing, bus.any_missing);
      end
      tick(wave(t_w, 1'b1) & 3'b101, par()); t_w++;
      total++;
      if (bus.rot_ok !== 1'b0) begin
         bad++;
         $display("FAIL miss_drop got=%b want=0", bus.rot_ok);
      end
      for (int n = 0; n < 2400; n++) begin
         tick(wave(t_w, 1'b1), par()); t_w++;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL miss_rec n=%0d got=%b want=%b", n,
                     obs_vec(), exp_vec());
         end
      end
      total++;
      if ({bus.missing, bus.rot_ok} !== 4'b0001) begin
         bad++;
         $display("FAIL miss_requal got=%b%b want=0001",
                  bus.missing, bus.rot_ok);
      end
   endtask

   task automatic test_simultaneous();
      bit seen;
      while (t_w % 120 != 105) begin
         tick(wave(t_w, 1'b1), par()); t_w++;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL sim_pre got=%b want=%b", obs_vec(), exp_vec());
         end
      end
      total++;
      if (bus.rot_ok !== 1'b1) begin
         bad++;
         $display("FAIL sim_qual got=%b want=1", bus.rot_ok);
      end
      repeat (14) tick(3'b000, par());
      seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
         tick(3'b101, par());
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL sim n=%0d got=%b want=%b", n,
                     obs_vec(), exp_vec());
         end
         if (bus.phase_rise === 3'b101) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL sim_timeout got=%b want=101", bus.phase_rise);
      end
      tick(3'b101, par());
      total++;
      if ({bus.rot_ok, bus.rot_rev} !== 2'b00) begin
         bad++;
         $display("FAIL sim_clear got=%b%b want=00", bus.rot_ok, bus.rot_rev);
      end
      for (int n = 0; n < 200; n++) begin
         tick(wave(t_w, 1'b1), par()); t_w++;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL sim_post n=%0d got=%b want=%b", n,
                     obs_vec(), exp_vec());
         end
      end
      total++;
      if (bus.rot_ok !== 1'b0) begin
         bad++;
         $display("FAIL sim_noinc got=%b want=0", bus.rot_ok);
      end
   endtask

   task automatic test_async_reset();
      for (int n = 0; n < 2400; n++) begin
         tick(wave(t_w, 1'b1), par()); t_w++;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL ar_pre n=%0d got=%b want=%b", n,
                     obs_vec(), exp_vec());
         end
      end
      total++;
      if (bus.rot_ok !== 1'b1) begin
         bad++;
         $display("FAIL ar_qual got=%b want=1", bus.rot_ok);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #0.5;
      total++;
      if (obs_vec() !== 13'd0) begin
         bad++;
         $display("FAIL ar_drop got=%b want=0", obs_vec());
      end
      #0.5 rst_n = 1'b1;
      for (int n = 0; n < 1800; n++) begin
         tick(wave(t_w, 1'b1), par()); t_w++;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL ar_post n=%0d got=%b want=%b", n,
                     obs_vec(), exp_vec());
         end
         if (n == 299) begin
            total++;
            if (bus.rot_ok !== 1'b0) begin
               bad++;
               $display("FAIL ar_early got=%b want=0", bus.rot_ok);
            end
         end
      end
      total++;
      if (bus.rot_ok !== 1'b1) begin
         bad++;
         $display("FAIL ar_requal got=%b want=1", bus.rot_ok);
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_random();
      test_forward();
      test_reverse();
      test_missing();
      test_simultaneous();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
